// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

endpackage

// File: rtl/tick_generator.sv
// Free-running divider producing a one-cycle enable every SOURCE_FREQ/TICK_FREQ clocks.
module tick_generator #(
   parameter int SOURCE_FREQ = 100_000_000,
   parameter int TICK_FREQ   = 1000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int TICK_DIV = SOURCE_FREQ / TICK_FREQ;
   localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset)     cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning matrix keypad decoder with press/release debounce on a slow scan tick.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SOURCE_FREQ    = 100_000_000,
   parameter int SCAN_FREQ      = 1000,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [COLS-1:0]               cols_n,
   output logic [ROWS-1:0]               rows_n,
   output logic [$clog2(ROWS*COLS)-1:0]  key_code,
   output logic                          key_valid,
   output logic                          key_held
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam int KW = $clog2(ROWS * COLS);

   logic tick;

   tick_generator #(
      .SOURCE_FREQ (SOURCE_FREQ),
      .TICK_FREQ   (SCAN_FREQ)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   logic [COLS-1:0] cols_meta, cols_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         cols_meta <= '1;
         cols_sync <= '1;
      end else begin
         cols_meta <= cols_n;
         cols_sync <= cols_meta;
      end
   end

   // Lowest-index active column wins when several are pressed in the same row.
   logic          any_low;
   logic [CW-1:0] low_col;

   always_comb begin
      low_col = '0;
      for (int c = COLS - 1; c >= 0; c--)
         if (!cols_sync[c]) low_col = CW'(c);
   end

   assign any_low = ~&cols_sync;

   scan_state_t   state;
   logic [RW-1:0] row, row_nxt;
   logic [CW-1:0] cap_col;
   logic [DW-1:0] cnt, cnt_inc;
   logic          cap_low;

   assign row_nxt = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
   assign cnt_inc = cnt + DW'(1);
   assign cap_low = ~cols_sync[cap_col];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SCAN;
         row       <= '0;
         rows_n    <= ~(ROWS'(1));
         cap_col   <= '0;
         cnt       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (tick) begin
            unique case (state)
               SCAN: begin
                  if (any_low) begin
                     cap_col <= low_col;
                     cnt     <= '0;
                     state   <= DEBOUNCE;
                  end else begin
                     row    <= row_nxt;
                     rows_n <= ~(ROWS'(1) << row_nxt);
                  end
               end
               DEBOUNCE: begin
                  if (!cap_low) begin
                     state  <= SCAN;
                     row    <= row_nxt;
                     rows_n <= ~(ROWS'(1) << row_nxt);
                  end else if (cnt_inc == DW'(DEBOUNCE_TICKS)) begin
                     key_code  <= KW'(int'(row) * COLS + int'(cap_col));
                     key_valid <= 1'b1;
                     key_held  <= 1'b1;
                     cnt       <= '0;
                     state     <= HELD;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               HELD: begin
                  if (!cap_low) begin
                     cnt   <= '0;
                     state <= RELEASE;
                  end
               end
               RELEASE: begin
                  // A bounce back to pressed resumes holding without a new press event.
                  if (cap_low) begin
                     cnt   <= '0;
                     state <= HELD;
                  end else if (cnt_inc == DW'(DEBOUNCE_TICKS)) begin
                     cnt      <= '0;
                     key_held <= 1'b0;
                     state    <= SCAN;
                     row      <= row_nxt;
                     rows_n   <= ~(ROWS'(1) << row_nxt);
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: a simulated key matrix driven through the scanner, checked every cycle
// against a tick-level model of press/release behaviour.
module tb_keypad_scanner;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int DT   = 3;
   localparam int DIV  = 10;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [COLS-1:0] cols_n;
   logic [ROWS-1:0] rows_n;
   logic [3:0]      key_code;
   logic            key_valid;
   logic            key_held;
   logic [ROWS*COLS-1:0] pressed = '0;

   always #5 clk = ~clk;

   keypad_scanner #(
      .ROWS           (ROWS),
      .COLS           (COLS),
      .SOURCE_FREQ    (100),
      .SCAN_FREQ      (10),
      .DEBOUNCE_TICKS (DT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cols_n    (cols_n),
      .rows_n    (rows_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   // Key matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      cols_n = '1;
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            if (pressed[r*COLS+c] && !rows_n[r]) cols_n[c] = 1'b0;
   end

   int compared = 0, mismatched = 0;
   int n = 0, pulses = 0, last_pulse_n = -1;

   // Model: row pointer, whether a key is locked (row frozen), accepted, and run lengths.
   int m_row, m_code, m_col, m_run, m_rel;
   bit m_locked, m_held, m_valid;

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         if (mismatched <= 30)
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
      end
   endtask

   function automatic int lowest_low(input int r);
      for (int c = 0; c < COLS; c++)
         if (pressed[r*COLS+c]) return c;
      return -1;
   endfunction

   task automatic model_tick();
      int c;
      if (!m_locked) begin
         c = lowest_low(m_row);
         if (c >= 0) begin
            m_locked = 1; m_col = c; m_run = 0;
         end else m_row = (m_row + 1) % ROWS;
      end else if (!m_held) begin
         if (pressed[m_row*COLS+m_col]) begin
            m_run++;
            if (m_run == DT) begin
               m_code = m_row * COLS + m_col; m_valid = 1; m_held = 1; m_rel = 0;
            end
         end else begin
            m_locked = 0; m_row = (m_row + 1) % ROWS;
         end
      end else begin
         // Release needs the first released tick plus DT more consecutive ones.
         if (pressed[m_row*COLS+m_col]) m_rel = 0;
         else begin
            m_rel++;
            if (m_rel == DT + 1) begin
               m_held = 0; m_locked = 0; m_row = (m_row + 1) % ROWS;
            end
         end
      end
   endtask

   task automatic clk_step();
      logic [3:0] er;
      @(posedge clk);
      n++;
      #1;
      m_valid = 0;
      if (n % DIV == 0) model_tick();
      if (key_valid) begin pulses++; last_pulse_n = n; end
      er = ~(4'(1) << m_row);
      check("rows_n", int'(rows_n), int'(er));
      check("key_code", int'(key_code), m_code);
      check("key_held", int'(key_held), int'(m_held));
      check("key_valid", int'(key_valid), int'(m_valid));
   endtask

   task automatic run_ticks(input int k);
      repeat (k * DIV) clk_step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_rows_n", int'(rows_n), 4'b1110);
      check("rst_key_code", int'(key_code), 0);
      check("rst_key_valid", int'(key_valid), 0);
      check("rst_key_held", int'(key_held), 0);
      reset = 1'b0;
      m_row = 0; m_code = 0; m_col = 0; m_run = 0; m_rel = 0;
      m_locked = 0; m_held = 0; m_valid = 0;
      n = 0; pulses = 0; last_pulse_n = -1;
   endtask

   typedef struct {
      logic [15:0] mask;
      int          hold;
      int          exp_pulses;
      int          exp_code;
   } vec_t;

   vec_t vecs[7];
   logic [3:0] seqr[5];

   initial begin
      vecs[0] = '{16'h0000, 10, 0, 0};    // idle
      vecs[1] = '{16'h0200, 10, 1, 9};    // row2 col1
      vecs[2] = '{16'h0090, 10, 1, 4};    // row1 cols 3 and 0
      vecs[3] = '{16'h8000, 10, 1, 15};   // row3 col3
      vecs[4] = '{16'h0C00, 10, 1, 10};   // row2 cols 3 and 2
      vecs[5] = '{16'h2002, 10, 1, 1};    // row0 col1 beats row3 key
      vecs[6] = '{16'h0200,  5, 0, 0};    // released mid-debounce
      seqr = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

      // Idle row walk
      do_reset();
      for (int i = 1; i < 5; i++) begin
         run_ticks(1);
         check("idle_rows", int'(rows_n), int'(seqr[i]));
      end
      check("idle_pulses", pulses, 0);

      // Table-driven press/release scenarios
      foreach (vecs[i]) begin
         do_reset();
         pressed = vecs[i].mask;
         run_ticks(vecs[i].hold);
         pressed = '0;
         run_ticks(6);
         check("vec_pulses", pulses, vecs[i].exp_pulses);
         check("vec_code", int'(key_code), vecs[i].exp_code);
         check("vec_held", int'(key_held), 0);
      end

      // Long hold: accept on tick 6, held until tick 14
      do_reset();
      pressed = 16'h0200;
      run_ticks(6);
      check("hold_pulse_cycle", last_pulse_n, 60);
      check("hold_code", int'(key_code), 9);
      run_ticks(4);
      pressed = '0;
      run_ticks(3);
      check("hold_still_held", int'(key_held), 1);
      run_ticks(1);
      check("hold_released", int'(key_held), 0);
      check("hold_rows_after", int'(rows_n), 4'b0111);
      check("hold_pulses", pulses, 1);

      // Bounce during release goes back to held without a second pulse
      do_reset();
      pressed = 16'h0200;
      run_ticks(6);
      pressed = '0;
      run_ticks(3);
      pressed = 16'h0200;
      run_ticks(1);
      check("bounce_held", int'(key_held), 1);
      pressed = '0;
      run_ticks(3);
      check("bounce_still_held", int'(key_held), 1);
      run_ticks(1);
      check("bounce_released", int'(key_held), 0);
      check("bounce_pulses", pulses, 1);
      check("bounce_rows", int'(rows_n), 4'b0111);

      // Reset in the middle of a debounce on row1
      pressed = 16'h0010;
      run_ticks(4);
      do_reset();
      repeat (DIV - 1) clk_step();
      check("first_tick_early", int'(rows_n), 4'b1110);
      clk_step();
      check("first_tick_on", int'(rows_n), 4'b1101);
      run_ticks(3);
      check("rst_abort_pulses", pulses, 0);
      run_ticks(1);
      check("rst_fresh_pulses", pulses, 1);
      check("rst_fresh_code", int'(key_code), 4);
      pressed = '0;
      run_ticks(6);

      // Random key activity, checked cycle by cycle
      do_reset();
      for (int it = 0; it < 40; it++) begin
         int k;
         pressed = '0;
         k = int'($urandom_range(0, 2));
         for (int j = 0; j < k; j++) pressed[$urandom_range(0, 15)] = 1'b1;
         run_ticks(int'($urandom_range(1, 8)));
      end
      pressed = '0;
      run_ticks(6);
      check("rand_idle_held", int'(key_held), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
